stopwatch_ctrl: RTL and testbench

//  Run/pause/lap controller that sequences a cascade of N_DIGITS BCD decade stages (0..9 each).

---
 rtl/stopwatch_ctrl_pkg.sv | 18 +
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl_decade_cell.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller and its decade cells.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StLap   = 2'd2,
        StPause = 2'd3
    } sw_state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == BCD_MAX) ? BCD_ZERO : d + 4'd1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display and status out; master drives buttons, slave is the controller.
interface stopwatch_ctrl_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                  start_stop;
    logic                  clear;
    logic                  lap;
    logic [4*N_DIGITS-1:0] bcd_disp;
    logic                  running;
    logic                  frozen;
    logic                  overflow;

    modport master (
        output start_stop, clear, lap,
        input  bcd_disp, running, frozen, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output bcd_disp, running, frozen, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl_decade_cell.sv
// One BCD decade stage: advances on en, wraps 9->0 and raises carry_out on the wrap.
module stopwatch_ctrl_decade_cell
    import stopwatch_ctrl_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = BCD_ZERO;
        end else if (en) begin
            q_d = bcd_inc(q);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            q <= BCD_ZERO;
        end else begin
            q <= q_d;
        end
    end

    assign carry_out = en && (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap stopwatch: FSM, tick prescaler, BCD decade cascade, lap freeze and overflow flag.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned N_DIGITS = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned    PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_e             state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [4*N_DIGITS-1:0] count;
    logic [4*N_DIGITS-1:0] lap_q, lap_d;
    logic                  overflow_q, overflow_d;
    logic                  running, frozen, tick, all_nine, ovf_hit;
    logic                  count_clr, lap_capture, presc_zero;
    logic [N_DIGITS:0]     carry;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!bus.clear && bus.start_stop) state_d = StRun;
            StRun:   if (bus.start_stop) state_d = StPause;
                     else if (bus.lap)   state_d = StLap;
            StLap:   if (bus.start_stop) state_d = StPause;
                     else if (bus.lap)   state_d = StRun;
            StPause: if (bus.clear)           state_d = StIdle;
                     else if (bus.start_stop) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        running = 1'b0;
        frozen  = 1'b0;
        case (state_q)
            StRun:   running = 1'b1;
            StLap:   begin running = 1'b1; frozen = 1'b1; end
            default: ;
        endcase
    end

    assign tick        = running && (presc_q == PRESC_LAST);
    assign count_clr   = ((state_q == StIdle) || (state_q == StPause)) && bus.clear;
    assign lap_capture = (state_q == StRun) && !bus.start_stop && bus.lap;
    assign presc_zero  = count_clr || ((state_q == StIdle) && bus.start_stop);

    always_comb begin
        all_nine = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (count[4*k +: 4] != BCD_MAX) all_nine = 1'b0;
        end
    end

    // Saturating mode blocks the tick at all-9s; wrapping mode lets the final carry signal overflow.
    assign carry[0] = tick && !(SATURATE && all_nine);
    assign ovf_hit  = SATURATE ? (tick && all_nine) : carry[N_DIGITS];

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        stopwatch_ctrl_decade_cell u_cell (
            .CLOCK_50  (CLOCK_50),
            .reset     (reset),
            .clr       (count_clr),
            .en        (carry[k]),
            .q         (count[4*k +: 4]),
            .carry_out (carry[k+1])
        );
    end

    always_comb begin
        presc_d = presc_q;
        if (presc_zero || tick) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign lap_d      = lap_capture ? count : lap_q;
    assign overflow_d = count_clr ? 1'b0 : (overflow_q || ovf_hit);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            lap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            lap_q      <= lap_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.bcd_disp = frozen ? lap_q : count;
    assign bus.running  = running;
    assign bus.frozen   = frozen;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: wrapping and saturating stopwatches share one stimulus stream, checked by a scoreboard.
module tb_stopwatch_ctrl;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic start_stop = 1'b0;
    logic clear      = 1'b0;
    logic lap        = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.N_DIGITS(2)) bus0 ();
    stopwatch_ctrl_if #(.N_DIGITS(2)) bus1 ();

    assign bus0.start_stop = start_stop;
    assign bus0.clear      = clear;
    assign bus0.lap        = lap;
    assign bus1.start_stop = start_stop;
    assign bus1.clear      = clear;
    assign bus1.lap        = lap;

    stopwatch_ctrl #(.TICK_DIV(4), .N_DIGITS(2), .SATURATE(1'b0)) dut0 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus0)
    );

    stopwatch_ctrl #(.TICK_DIV(4), .N_DIGITS(2), .SATURATE(1'b1)) dut1 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus1)
    );

    typedef struct packed {
        logic       sel;
        logic [7:0] disp;
        logic       run;
        logic       frz;
        logic       ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // sel: 0 = wrapping DUT, 1 = saturating DUT, 2 = both
    task automatic check(input string name, input int sel, input logic [7:0] disp,
                         input logic run, input logic frz, input logic ovf);
        if (sel == 0 || sel == 2) begin
            exp_q.push_back('{1'b0, disp, run, frz, ovf});
            name_q.push_back(name);
        end
        if (sel == 1 || sel == 2) begin
            exp_q.push_back('{1'b1, disp, run, frz, ovf});
            name_q.push_back(name);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        string      n;
        logic [7:0] ad;
        logic       ar, af, ao;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e.sel) begin
                ad = bus1.bcd_disp; ar = bus1.running; af = bus1.frozen; ao = bus1.overflow;
            end else begin
                ad = bus0.bcd_disp; ar = bus0.running; af = bus0.frozen; ao = bus0.overflow;
            end
            vectors++;
            if ({ad, ar, af, ao} !== {e.disp, e.run, e.frz, e.ovf}) begin
                miscompares++;
                $display("FAIL %s dut%0d: got disp=%h run=%b frz=%b ovf=%b, want disp=%h run=%b frz=%b ovf=%b",
                         n, e.sel, ad, ar, af, ao, e.disp, e.run, e.frz, e.ovf);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic c, input logic l);
        start_stop = s;
        clear      = c;
        lap        = l;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        step(1);
        check("reset_state", 2, 8'h00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({bus0.bcd_disp, bus0.running, bus0.frozen, bus0.overflow,
             bus1.bcd_disp, bus1.running, bus1.frozen, bus1.overflow} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_state_direct: dut0 disp=%h run=%b frz=%b ovf=%b dut1 disp=%h run=%b frz=%b ovf=%b",
                     bus0.bcd_disp, bus0.running, bus0.frozen, bus0.overflow,
                     bus1.bcd_disp, bus1.running, bus1.frozen, bus1.overflow);
        end
        step(1);
        reset = 1'b0;
        step(1);

        press(1'b0, 1'b0, 1'b1);
        check("idle_lap_ignored", 2, 8'h00, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        step(40);
        check("run_40_cycles", 2, 8'h10, 1'b1, 1'b0, 1'b0);

        // Pause with the prescaler two counts into its period
        step(1);
        press(1'b1, 1'b0, 1'b0);
        check("pause_enter", 2, 8'h10, 1'b0, 1'b0, 1'b0);
        step(20);
        check("pause_hold", 2, 8'h10, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({bus0.bcd_disp, bus0.running, bus1.bcd_disp, bus1.running} !== {8'h10, 1'b0, 8'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL pause_wait_expired: dut0 disp=%h run=%b dut1 disp=%h run=%b, want disp=10 run=0",
                     bus0.bcd_disp, bus0.running, bus1.bcd_disp, bus1.running);
        end
        press(1'b1, 1'b0, 1'b0);
        step(1);
        check("resume_not_early", 2, 8'h10, 1'b1, 1'b0, 1'b0);
        step(1);
        check("resume_two_cycles", 2, 8'h11, 1'b1, 1'b0, 1'b0);

        press(1'b0, 1'b1, 1'b0);
        check("run_clear_ignored", 2, 8'h11, 1'b1, 1'b0, 1'b0);

        step(350);
        check("count_98", 2, 8'h98, 1'b1, 1'b0, 1'b0);
        step(1);
        check("count_99", 2, 8'h99, 1'b1, 1'b0, 1'b0);
        step(4);
        check("overflow_wrap", 0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("overflow_saturate", 1, 8'h99, 1'b1, 1'b0, 1'b1);

        press(1'b1, 1'b0, 1'b0);
        check("pause_after_ovf_wrap", 0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("pause_after_ovf_sat", 1, 8'h99, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0);
        check("pause_clear_wins", 2, 8'h00, 1'b0, 1'b0, 1'b0);
        step(10);
        check("idle_no_ticks", 2, 8'h00, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        step(20);
        check("pre_lap_05", 2, 8'h05, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("lap_freeze", 2, 8'h05, 1'b1, 1'b1, 1'b0);
        step(12);
        check("lap_hold", 2, 8'h05, 1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("lap_release_live", 2, 8'h08, 1'b1, 1'b0, 1'b0);
        step(1);
        press(1'b0, 1'b0, 1'b1);
        check("lap_on_tick_pre_value", 2, 8'h08, 1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("live_after_tick_lap", 2, 8'h09, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("lap_again", 2, 8'h09, 1'b1, 1'b1, 1'b0);
        step(1);

        // Reset lands between clock edges; outputs must clear before the next edge
        reset = 1'b1;
        check("async_reset_in_lap", 2, 8'h00, 1'b0, 1'b0, 1'b0);
        step(2);
        reset = 1'b0;
        step(12);
        check("post_reset_idle", 2, 8'h00, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
